// File: rtl/hdlc_bus_sequencer.sv
// hdlc_bus_sequencer: TX stream to Tx_Buff and RX frame drain sharing one round-robin Hdlc register bus
module hdlc_bus_sequencer #(
  parameter int MAX_FRAME = 126
) (
  input  logic       Clk,
  input  logic       Rst,
  output logic [2:0] Address,
  output logic       WriteEnable,
  output logic       ReadEnable,
  output logic [7:0] DataIn,
  input  logic [7:0] DataOut,
  input  logic       Tx_Done,
  input  logic       Rx_Ready,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       rx_last,
  input  logic       rx_ready,
  output logic       tx_err,
  output logic       rx_err
);
  typedef enum logic [2:0] {T_IDLE, T_LOAD, T_START, T_RUN, T_WAIT, T_ABORT, T_FLUSH} tx_state_t;
  typedef enum logic [2:0] {R_IDLE, R_STAT, R_LEN, R_DATA, R_DROP, R_DONE} rx_state_t;
  tx_state_t ts, ts_nx;
  rx_state_t rs, rs_nx;
  logic [6:0] cnt, cnt_nx;
  logic [7:0] rem;
  logic rd_pend, ptr_rx;
  logic tx_req, rx_req, grant_tx, grant_rx, tx_load, tx_full, tx_acc, tx_wr, rx_wr, rx_rd, rx_take;
  always_comb begin
    tx_load = ts == T_IDLE || ts == T_LOAD;
    tx_full = cnt == 7'(MAX_FRAME);
    tx_req = Rst && (ts == T_IDLE ? tx_valid && Tx_Done : ts == T_LOAD ? tx_valid : ts == T_START || ts == T_ABORT);
    rx_req = Rst && (rs == R_STAT || rs == R_LEN ? !rd_pend :
                     rs == R_DATA ? !rd_pend && (!rx_valid || rx_ready) && rem != 8'd0 : rs == R_DROP);
    grant_tx = tx_req && (!rx_req || !ptr_rx);
    grant_rx = rx_req && (!tx_req || ptr_rx);
    tx_acc = grant_tx && tx_load;
    tx_ready = tx_acc || (Rst && ts == T_FLUSH);
    tx_wr = grant_tx && !(tx_load && tx_full && !tx_last);
    tx_err = grant_tx && ts == T_ABORT;
    rx_wr = grant_rx && rs == R_DROP;
    rx_rd = grant_rx && rs != R_DROP;
    rx_err = rx_wr;
    rx_take = rx_valid && rx_ready;
    WriteEnable = tx_wr || rx_wr;
    ReadEnable = rx_rd;
    Address = tx_wr ? {2'b00, tx_load} : rx_wr ? 3'd2 :
              rx_rd ? (rs == R_STAT ? 3'd2 : rs == R_LEN ? 3'd4 : 3'd3) : 3'd0;
    DataIn = tx_wr ? (tx_load ? tx_data : ts == T_START ? 8'h02 : 8'h04) : rx_wr ? 8'h02 : 8'h00;
  end
  always_comb begin
    ts_nx = ts;
    cnt_nx = cnt;
    case (ts)
      T_IDLE, T_LOAD: if (tx_acc) begin
        cnt_nx = cnt + 7'd1;
        ts_nx = tx_last ? T_START : tx_full ? T_ABORT : T_LOAD;
      end
      T_START: if (grant_tx) begin
        cnt_nx = '0;
        ts_nx = T_RUN;
      end
      T_RUN: ts_nx = Tx_Done ? T_RUN : T_WAIT;
      T_WAIT: ts_nx = Tx_Done ? T_IDLE : T_WAIT;
      T_ABORT: if (grant_tx) begin
        cnt_nx = '0;
        ts_nx = T_FLUSH;
      end
      T_FLUSH: ts_nx = tx_valid && tx_last ? T_IDLE : T_FLUSH;
      default: ts_nx = T_IDLE;
    endcase
  end
  always_comb begin
    rs_nx = rs;
    case (rs)
      R_IDLE: rs_nx = Rx_Ready ? R_STAT : R_IDLE;
      R_STAT: if (rd_pend) rs_nx = |DataOut[4:2] ? R_DROP : R_LEN;
      R_LEN: if (rd_pend) rs_nx = DataOut == 8'd0 ? R_DROP : R_DATA;
      R_DATA: rs_nx = rx_take && rx_last ? R_DONE : R_DATA;
      R_DROP: rs_nx = grant_rx ? R_DONE : R_DROP;
      R_DONE: rs_nx = Rx_Ready ? R_DONE : R_IDLE;
      default: rs_nx = R_IDLE;
    endcase
  end
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      ts <= T_IDLE;
      rs <= R_IDLE;
      cnt <= '0;
      rem <= '0;
      rd_pend <= 1'b0;
      ptr_rx <= 1'b1;
      rx_valid <= 1'b0;
      rx_data <= '0;
      rx_last <= 1'b0;
    end else begin
      ts <= ts_nx;
      rs <= rs_nx;
      cnt <= cnt_nx;
      rd_pend <= rx_rd;
      if (tx_req && rx_req) ptr_rx <= !ptr_rx;
      if (rx_take) begin
        rx_valid <= 1'b0;
        rx_last <= 1'b0;
      end
      if (rd_pend && rs == R_LEN) rem <= DataOut;
      if (rd_pend && rs == R_DATA) begin
        rx_data <= DataOut;
        rx_valid <= 1'b1;
        rx_last <= rem == 8'd1;
        rem <= rem - 8'd1;
      end
    end
  end
endmodule
